texture_loader: RTL and testbench
=================================

// Module: texture_loader
// PURPOSE
//  Boot-time sequencer that fills the wall-texture memory from external SPI flash, replacing
//  sim-only preload. On start: issue SPI READ (0x03) + 24-bit base address, stream 2**ADDR_BITS
//  bytes, write each byte into the texture memory write port at sequential addresses.
//  Sits between the chip's SPI flash pins and the texture memory; the renderer must not sample
//  texture data until tex_ready=1.
// PARAMETERS
//  ADDR_BITS   13         texture memory address width; bytes loaded = 2**ADDR_BITS
//  FLASH_BASE  24'h000000 flash byte address of first texture byte
// PORTS
//  clk       in   1          system clock
//  reset_n   in   1          asynchronous, active-low reset
//  start     in   1          request a (re)load; sampled only in IDLE/DONE
//  busy      out  1          load in progress (CMD..FINISH)
//  tex_ready out  1          load completed; held until next accepted start or reset
//  spi_csb   out  1          flash chip select, active low
//  spi_sclk  out  1          flash clock, mode 0 (idles low), = clk/2 while active
//  spi_mosi  out  1          flash data in, MSB first
//  spi_miso  in   1          flash data out
//  tex_we    out  1          texture memory write strobe, one clk per byte
//  tex_addr  out  ADDR_BITS  texture memory write address
//  tex_data  out  8          texture memory write data
// BEHAVIOUR
//  - Reset (async, any state): IDLE; spi_csb=1, spi_sclk=0, spi_mosi=0, busy=0, tex_ready=0,
//    tex_we=0, tex_addr=0, tex_data=0. Partial load is abandoned; no resume.
//  - States: IDLE -> CMD (8 bits) -> ADDR (24 bits) -> DATA (8*2**ADDR_BITS bits) -> FINISH -> DONE.
//    DONE behaves like IDLE but with tex_ready=1; start in DONE begins a full reload.
//  - Accept: edge where state in {IDLE,DONE} and start=1 -> CMD; at that edge spi_csb=0,
//    busy=1, tex_ready=0, tex_addr=0, spi_mosi=bit7 of 0x03. start while busy is ignored.
//  - Bit timing: each bit = 2 clk. Phase0: sclk=0, mosi holds current bit. Phase1: sclk=1.
//    At edge ending phase1: sclk->0, miso sampled into shift reg (DATA only), mosi advances.
//    Header bits sent MSB first: 0x03, then FLASH_BASE[23:0]. mosi=0 during DATA.
//  - Byte write: at the edge sampling the 8th bit of a data byte, tex_data<=assembled byte
//    (first sampled bit = MSB), tex_we<=1 for exactly one cycle at current tex_addr; tex_addr
//    increments the following edge (i.e. with tex_we deassertion). Next byte's phase0 overlaps
//    the tex_we cycle; sclk never stalls mid-transfer.
//  - Address counter: tex_addr runs 0..2**ADDR_BITS-1, no wrap; last-byte write -> FINISH
//    (tex_addr stays at max, not wrapped to 0).
//  - FINISH: one cycle; next edge: spi_csb=1, sclk=0, busy=0, tex_ready=1, tex_we=0 -> DONE.
//  - Latency: accept edge to tex_ready edge = 64 + 16*2**ADDR_BITS + 1 clk.
//  - spi_csb low continuously from accept to FINISH; sclk only toggles while csb=0.
//  - Simultaneous start and reset_n=0: reset wins.
// TESTING
//  1 Reset: assert reset_n=0 mid-DATA -> same cycle csb=1, sclk=0, busy=0, tex_we=0, tex_ready=0.
//  2 Header: ADDR_BITS=4, FLASH_BASE=24'h012345, pulse start -> mosi shows 0x03 then 0x012345
//    MSB first on 32 sclk rising edges; csb low from accept edge.
//  3 Stream: flash model returns byte k = 8'hA0+k -> 16 tex_we pulses, tex_addr 0..15,
//    tex_data A0..AF; tex_ready rises exactly 64+256+1=321 clk after accept.
//  4 Busy start: pulse start repeatedly during DATA -> no effect, single 16-byte load, same timing.
//  5 Reload: start in DONE -> tex_ready drops at accept edge, full header + 16 writes repeated.
//  6 Reset during ADDR then start -> clean full load from tex_addr=0; no stray tex_we before DATA.

Source files
------------

// File: rtl/texture_loader_if.sv
// Texture loader signal bundle: start/status, SPI flash pins and texture memory write port.
interface texture_loader_if #(
  parameter int ADDR_BITS = 13
);
  logic                 start;
  logic                 busy;
  logic                 tex_ready;
  logic                 spi_csb;
  logic                 spi_sclk;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic                 tex_we;
  logic [ADDR_BITS-1:0] tex_addr;
  logic [7:0]           tex_data;

  modport master (
    input  start, spi_miso,
    output busy, tex_ready, spi_csb, spi_sclk, spi_mosi, tex_we, tex_addr, tex_data
  );

  modport slave (
    output start, spi_miso,
    input  busy, tex_ready, spi_csb, spi_sclk, spi_mosi, tex_we, tex_addr, tex_data
  );
endinterface

// File: rtl/texture_loader.sv
// Boot-time loader: SPI READ 0x03 + 24-bit base, streams 2**ADDR_BITS bytes into texture memory.
// Accept to tex_ready = 64 + 16*2**ADDR_BITS + 1 clk; start is ignored while busy, no backpressure.
module texture_loader #(
  parameter int          ADDR_BITS  = 13,
  parameter logic [23:0] FLASH_BASE = 24'h000000
) (
  input logic              clk,
  input logic              reset_n,
  texture_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    FINISH = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [31:0]          HDR      = {8'h03, FLASH_BASE};
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

  state_t               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [31:0]          sh_q, sh_d;
  logic [7:0]           rx_q, rx_d;
  logic                 csb_q, csb_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           data_q, data_d;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    rx_d      = rx_q;
    csb_d     = csb_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = CMD;
          csb_d     = 1'b0;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
          addr_d    = '0;
          phase_d   = 1'b0;
          sclk_d    = 1'b0;
          bit_cnt_d = 5'd0;
          mosi_d    = HDR[31];
          sh_d      = {HDR[30:0], 1'b0};
        end
      end

      CMD, ADDR, DATA: begin
        // Address advances on the edge that drops the write strobe.
        if (state_q == DATA && we_q) begin
          addr_d = addr_q + ADDR_ONE;
        end
        if (!phase_q) begin
          phase_d = 1'b1;
          sclk_d  = 1'b1;
        end else begin
          phase_d   = 1'b0;
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (state_q == CMD) begin
            mosi_d = sh_q[31];
            sh_d   = {sh_q[30:0], 1'b0};
            if (bit_cnt_q == 5'd7) begin
              state_d   = ADDR;
              bit_cnt_d = 5'd0;
            end
          end else if (state_q == ADDR) begin
            mosi_d = sh_q[31];
            sh_d   = {sh_q[30:0], 1'b0};
            if (bit_cnt_q == 5'd23) begin
              state_d   = DATA;
              bit_cnt_d = 5'd0;
              mosi_d    = 1'b0;
            end
          end else begin
            rx_d = {rx_q[6:0], bus.spi_miso};
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              we_d      = 1'b1;
              data_d    = rx_d;
              // Last byte keeps tex_addr at max instead of wrapping.
              if (addr_q == ADDR_MAX) begin
                state_d = FINISH;
              end
            end
          end
        end
      end

      FINISH: begin
        state_d = DONE;
        csb_d   = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        csb_d   = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      bit_cnt_q <= 5'd0;
      sh_q      <= 32'd0;
      rx_q      <= 8'd0;
      csb_q     <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      rx_q      <= rx_d;
      csb_q     <= csb_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign bus.spi_csb   = csb_q;
  assign bus.spi_sclk  = sclk_q;
  assign bus.spi_mosi  = mosi_q;
  assign bus.busy      = busy_q;
  assign bus.tex_ready = ready_q;
  assign bus.tex_we    = we_q;
  assign bus.tex_addr  = addr_q;
  assign bus.tex_data  = data_q;

endmodule

// File: tb/tb_texture_loader.sv
// Directed bench for texture_loader with a behavioural SPI flash (ADDR_BITS=4, base 0x012345).
module tb_texture_loader;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  texture_loader_if #(.ADDR_BITS(4)) bus ();

  texture_loader #(
    .ADDR_BITS (4),
    .FLASH_BASE(24'h012345)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] flash_byte;
    logic [3:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t va[16];
  vec_t vb[16];
  vec_t cur[16];

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash model: captures header bits on sclk rise, presents data bits for the next sample.
  logic [7:0]  flash_mem[16];
  logic [31:0] hdr_cap;
  int          rc;
  int          bi;
  logic [7:0]  fb;
  bit          glitch_mosi = 1'b0;

  always @(posedge bus.spi_sclk or negedge bus.spi_csb) begin
    if (!bus.spi_sclk) begin
      rc          = 0;
      hdr_cap     = 32'd0;
      bus.spi_miso = 1'b0;
    end else if (!bus.spi_csb) begin
      if (rc < 32) begin
        hdr_cap = {hdr_cap[30:0], bus.spi_mosi};
      end else begin
        if (bus.spi_mosi !== 1'b0) glitch_mosi = 1'b1;
        bi = rc - 32;
        if (bi < 128) begin
          fb           = flash_mem[bi[6:3]];
          bus.spi_miso = fb[~bi[2:0]];
        end
      end
      rc = rc + 1;
    end
  end

  // Write-port and SPI-framing monitor.
  logic [3:0] wr_addr[128];
  logic [7:0] wr_data[128];
  int         wr_cyc[128];
  int         wr_n = 0;
  bit         glitch_csb = 1'b0;

  always @(negedge clk) begin
    if (bus.tex_we === 1'b1 && wr_n < 128) begin
      wr_addr[wr_n] <= bus.tex_addr;
      wr_data[wr_n] <= bus.tex_data;
      wr_cyc[wr_n]  <= cyc;
      wr_n          <= wr_n + 1;
    end
    if (bus.busy === 1'b1 && bus.spi_csb !== 1'b0) glitch_csb <= 1'b1;
    if (bus.spi_csb === 1'b1 && bus.spi_sclk !== 1'b0) glitch_csb <= 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_load(input string tag, input bit spam);
    int base;
    int acc;
    int n;
    bit seen;
    for (int k = 0; k < 16; k++) flash_mem[k] = cur[k].flash_byte;
    base = wr_n;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    acc = cyc;
    check({tag, "_accept_csb"},   32'(bus.spi_csb),   32'd0);
    check({tag, "_accept_busy"},  32'(bus.busy),      32'd1);
    check({tag, "_accept_ready"}, 32'(bus.tex_ready), 32'd0);
    check({tag, "_accept_addr"},  32'(bus.tex_addr),  32'd0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 400) begin
      bus.start = spam && (n % 23 == 3);
      @(negedge clk);
      n++;
      if (bus.tex_ready === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd321);
    check({tag, "_header"}, hdr_cap, 32'h03012345);
    check({tag, "_writes"}, 32'(wr_n - base), 32'd16);
    if (wr_n - base >= 16) begin
      check({tag, "_first_wr_cyc"}, 32'(wr_cyc[base] - acc), 32'd80);
      for (int k = 0; k < 16; k++) begin
        check($sformatf("%s_addr%0d", tag, k), 32'(wr_addr[base+k]), 32'(cur[k].exp_addr));
        check($sformatf("%s_data%0d", tag, k), 32'(wr_data[base+k]), 32'(cur[k].exp_data));
      end
    end
    check({tag, "_done_busy"}, 32'(bus.busy),     32'd0);
    check({tag, "_done_csb"},  32'(bus.spi_csb),  32'd1);
    check({tag, "_done_addr"}, 32'(bus.tex_addr), 32'd15);
    check({tag, "_framing"},   32'(glitch_csb),   32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      va[k] = '{flash_byte: 8'hA0 + 8'(k), exp_addr: 4'(k), exp_data: 8'hA0 + 8'(k)};
      vb[k] = '{flash_byte: 8'h3C ^ 8'(k * 17), exp_addr: 4'(k), exp_data: 8'h3C ^ 8'(k * 17)};
    end
    vb[0].exp_data  = 8'h3C;
    vb[15].exp_data = 8'hC3;

    repeat (3) @(negedge clk);
    check("rst_csb",   32'(bus.spi_csb),   32'd1);
    check("rst_sclk",  32'(bus.spi_sclk),  32'd0);
    check("rst_mosi",  32'(bus.spi_mosi),  32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_ready", 32'(bus.tex_ready), 32'd0);
    check("rst_we",    32'(bus.tex_we),    32'd0);
    check("rst_addr",  32'(bus.tex_addr),  32'd0);
    check("rst_data",  32'(bus.tex_data),  32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    cur = va;
    run_load("load1", 1'b0);

    repeat (3) @(negedge clk);
    check("done_ready_held", 32'(bus.tex_ready), 32'd1);
    cur = vb;
    run_load("reload_spam", 1'b1);

    #1 reset_n = 1'b0;
    #1 check("rst_done_ready", 32'(bus.tex_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Abort mid-DATA exactly while a write strobe is high.
    for (int k = 0; k < 16; k++) flash_mem[k] = va[k].flash_byte;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      bit got_we;
      got_we = 1'b0;
      for (int n = 0; n < 400 && !got_we; n++) begin
        @(negedge clk);
        if (bus.tex_we === 1'b1) got_we = 1'b1;
      end
      check("mid_data_we_seen", 32'(got_we), 32'd1);
    end
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_csb",   32'(bus.spi_csb),   32'd1);
    check("mid_rst_sclk",  32'(bus.spi_sclk),  32'd0);
    check("mid_rst_busy",  32'(bus.busy),      32'd0);
    check("mid_rst_we",    32'(bus.tex_we),    32'd0);
    check("mid_rst_ready", 32'(bus.tex_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Abort during the address phase, then a clean full load.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check("addr_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cur = va;
    run_load("after_addr_rst", 1'b0);

    check("mosi_low_in_data", 32'(glitch_mosi), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
